// File: rtl/fetch_hazard_controller.sv
// Fetch/Decode hazard sequencer: load-use stall, taken-branch flush and halt/resume,
// with saturating stall and flush cycle counters.
module fetch_hazard_controller #(
  parameter int LOAD_STALL_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memRead_Execute,
  input  logic [4:0]  rd_Execute,
  input  logic [4:0]  rn_Decode,
  input  logic [4:0]  rm_Decode,
  input  logic        useRm_Decode,
  input  logic        BrTaken_Decode,
  input  logic        halt_Decode,
  input  logic        resume,
  output logic        pcEnable,
  output logic        ifIdEnable,
  output logic        ifIdFlush,
  output logic        idExBubble,
  output logic        halted,
  output logic [15:0] stallCount,
  output logic [15:0] flushCount
);

  typedef enum logic [1:0] {RUN, STALL, HALT} state_t;

  localparam logic [3:0] REMAIN_INIT = 4'(LOAD_STALL_CYCLES - 1);

  state_t      state_q, state_d;
  logic [3:0]  remain_q, remain_d;
  logic [15:0] stall_cnt_q, flush_cnt_q;
  logic        load_use;
  logic        stall_cyc;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // XZR (r31) is never a real producer, so it cannot create a hazard.
  assign load_use = memRead_Execute && (rd_Execute != 5'd31) &&
                    ((rd_Execute == rn_Decode) ||
                     (useRm_Decode && (rd_Execute == rm_Decode)));

  always_comb begin
    state_d    = state_q;
    remain_d   = remain_q;
    pcEnable   = 1'b1;
    ifIdEnable = 1'b1;
    ifIdFlush  = 1'b0;
    idExBubble = 1'b0;
    halted     = 1'b0;
    stall_cyc  = 1'b0;
    case (state_q)
      RUN: begin
        if (load_use) begin
          // Branch operands are not yet valid, so a pending branch waits.
          pcEnable   = 1'b0;
          ifIdEnable = 1'b0;
          idExBubble = 1'b1;
          stall_cyc  = 1'b1;
          if (LOAD_STALL_CYCLES > 1) begin
            state_d  = STALL;
            remain_d = REMAIN_INIT;
          end
        end else if (halt_Decode) begin
          pcEnable   = 1'b0;
          ifIdEnable = 1'b0;
          idExBubble = 1'b1;
          state_d    = HALT;
        end else if (BrTaken_Decode) begin
          ifIdFlush = 1'b1;
        end
      end
      STALL: begin
        pcEnable   = 1'b0;
        ifIdEnable = 1'b0;
        idExBubble = 1'b1;
        stall_cyc  = 1'b1;
        remain_d   = remain_q - 4'd1;
        if (remain_q == 4'd1) state_d = RUN;
      end
      HALT: begin
        halted     = 1'b1;
        idExBubble = 1'b1;
        // On resume the held HALT+4 instruction overwrites HALT in IF/ID.
        pcEnable   = resume;
        ifIdEnable = resume;
        if (resume) state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= RUN;
      remain_q    <= 4'd0;
      stall_cnt_q <= 16'd0;
      flush_cnt_q <= 16'd0;
    end else begin
      state_q  <= state_d;
      remain_q <= remain_d;
      if (stall_cyc) stall_cnt_q <= sat_inc(stall_cnt_q);
      if (ifIdFlush) flush_cnt_q <= sat_inc(flush_cnt_q);
    end
  end

  assign stallCount = stall_cnt_q;
  assign flushCount = flush_cnt_q;

endmodule
